nv_ram_rwsthp_20x32_fifo_ctrl: RTL and testbench

- Sequencing controller that turns the 20x32 two-port RAM with read bypass and registered output into a 21-entry valid/ready FIFO.
- Entries: 20 RAM slots plus the RAM output register.
- Generates all RAM controls (ra/re, ore, wa/we/di, byp_sel/dbyp) and hides the 2-cycle RAM read latency behind a stall-safe pipeline.
- When the FIFO is empty, incoming data goes through the RAM bypass path for 1-cycle latency.

---
 rtl/nv_ram_rwsthp_20x32_fifo_ctrl.sv | 97 +++++++++
 tb/tb_nv_ram_rwsthp_20x32_fifo_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsthp_20x32_fifo_ctrl.sv
// Sequencing controller that turns the 20x32 two-port RAM (read bypass,
// registered output) into a 21-entry valid/ready FIFO. 20 entries live in
// RAM slots, one in the RAM output register. The two-cycle read (address
// register, then output register) is kept full ahead of the consumer and
// stalls in place when the consumer is not ready.
module nv_ram_rwsthp_20x32_fifo_ctrl #(
    parameter int BYPASS_EN = 1,
    parameter int DEPTH     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [31:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [31:0] rd_pd,
    output logic [4:0]  fifo_count,
    output logic [4:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    output logic [4:0]  ram_wa,
    output logic        ram_we,
    output logic [31:0] ram_di,
    output logic        ram_byp_sel,
    output logic [31:0] ram_dbyp,
    input  logic [31:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd_in,
    output logic [31:0] pwrbus_ram_pd
);

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);
    localparam logic [4:0] LAST_C  = 5'(DEPTH - 1);
    localparam logic       BYP_ON  = (BYPASS_EN != 0);

    // Slot pointers, slot occupancy (includes the address held in ra_d),
    // entries written but not yet issued, and the two read-stage valids.
    logic [4:0] wr_ptr, rd_ptr;
    logic [4:0] slot_cnt, unread_cnt;
    logic       s1_vld, out_vld;

    logic pop, adv, iss, byp, push;

    // Handshake and pipeline-advance decode. The bypass path is only taken
    // when nothing older sits in RAM or the address stage, and the output
    // register is free or draining this cycle.
    always_comb begin
        wr_prdy = (slot_cnt < DEPTH_C);
        pop     = out_vld & rd_prdy;
        adv     = s1_vld & (~out_vld | rd_prdy);
        iss     = (unread_cnt != 5'd0) & (~s1_vld | adv);
        byp     = BYP_ON & wr_pvld & (slot_cnt == 5'd0) & ~s1_vld
                  & (~out_vld | rd_prdy);
        push    = wr_pvld & wr_prdy & ~byp;
    end

    // RAM-facing controls; enables are held off while reset is asserted so
    // the RAM sees no activity during reset.
    always_comb begin
        ram_re        = iss & ~rst;
        ram_ra        = rd_ptr;
        ram_ore       = (adv | byp) & ~rst;
        ram_byp_sel   = byp & ~rst;
        ram_dbyp      = wr_pd;
        ram_we        = push & ~rst;
        ram_wa        = wr_ptr;
        ram_di        = wr_pd;
        rd_pvld       = out_vld;
        rd_pd         = ram_dout;
        fifo_count    = slot_cnt + {4'd0, out_vld};
        pwrbus_ram_pd = pwrbus_ram_pd_in;
    end

    // Pointer, counter and stage-valid update. A slot is released only when
    // its data is captured by the output register, so an address held in
    // ra_d during a stall can never be overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 5'd0;
            rd_ptr     <= 5'd0;
            slot_cnt   <= 5'd0;
            unread_cnt <= 5'd0;
            s1_vld     <= 1'b0;
            out_vld    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST_C) ? 5'd0 : wr_ptr + 5'd1;
            if (iss)
                rd_ptr <= (rd_ptr == LAST_C) ? 5'd0 : rd_ptr + 5'd1;
            slot_cnt   <= slot_cnt + {4'd0, push} - {4'd0, adv};
            unread_cnt <= unread_cnt + {4'd0, push} - {4'd0, iss};
            s1_vld     <= iss | (s1_vld & ~adv);
            out_vld    <= adv | byp | (out_vld & ~pop);
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsthp_20x32_fifo_ctrl.sv
// Bench for the 21-entry RAM-backed FIFO controller. A behavioural RAM
// (bypass + registered output) closes the loop; a queue of accepted words
// is the reference for ordering, occupancy and read data.
module tb_nv_ram_rwsthp_20x32_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pvld, wr_prdy;
    logic [31:0] wr_pd;
    logic        rd_pvld, rd_prdy;
    logic [31:0] rd_pd;
    logic [4:0]  fifo_count;
    logic [4:0]  ram_ra, ram_wa;
    logic        ram_re, ram_ore, ram_we, ram_byp_sel;
    logic [31:0] ram_di, ram_dbyp, ram_dout;
    logic [31:0] pwrbus_ram_pd_in, pwrbus_ram_pd;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    nv_ram_rwsthp_20x32_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .fifo_count(fifo_count),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp), .ram_dout(ram_dout),
        .pwrbus_ram_pd_in(pwrbus_ram_pd_in), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    // Behavioural 20x32 RAM: address register on re, output register on ore.
    logic [31:0] mem [0:19];
    logic [4:0]  ra_d;
    always @(posedge clk) begin
        if (ram_we && ram_wa < 5'd20) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : ((ra_d < 5'd20) ? mem[ra_d] : 32'hx);
    end

    // Called at the negedge: records this cycle's handshakes, crosses the
    // edge and applies them to the reference queue.
    task automatic advance(output logic a, output logic p);
        logic [31:0] d;
        a = wr_pvld & wr_prdy & ~rst;
        p = rd_pvld & rd_prdy & ~rst;
        d = wr_pd;
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (p && q.size() > 0) void'(q.pop_front());
            if (a) q.push_back(d);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
    endtask

    // Back-to-back writes with the consumer stalled; words are 0,1,2,...
    task automatic fill(input int n, output int got);
        logic a, p;
        got = 0;
        rd_prdy = 1'b0;
        for (int i = 0; i < n + 10 && got < n; i++) begin
            wr_pvld = 1'b1; wr_pd = 32'(got);
            @(negedge clk);
            advance(a, p);
            got += int'(a);
        end
        wr_pvld = 1'b0;
    endtask

    task automatic test_reset();
        logic a, p;
        rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = 32'h0;
        pwrbus_ram_pd_in = $urandom;
        repeat (2) @(posedge clk);
        #1; wr_pvld = 1'b1; rd_prdy = 1'b1;
        @(negedge clk);
        checks++; if ({ram_we, ram_re, ram_ore} !== 3'b000) begin errors++;
            $display("FAIL reset_enables got %b exp 000", {ram_we, ram_re, ram_ore}); end
        checks++; if (pwrbus_ram_pd !== pwrbus_ram_pd_in) begin errors++;
            $display("FAIL pwrbus got %h exp %h", pwrbus_ram_pd, pwrbus_ram_pd_in); end
        @(posedge clk); #1;
        rst = 1'b0; wr_pvld = 1'b0; q.delete();
        @(negedge clk);
        checks++; if ({rd_pvld, wr_prdy, fifo_count} !== {1'b0, 1'b1, 5'd0}) begin errors++;
            $display("FAIL reset_state got vld=%b rdy=%b cnt=%0d exp 0 1 0", rd_pvld, wr_prdy, fifo_count); end
        advance(a, p);
    endtask

    task automatic test_bypass_single();
        logic a, p;
        wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 32'hA5A5_0001;
        @(negedge clk);
        checks++; if ({ram_byp_sel, ram_ore, ram_we} !== 3'b110) begin errors++;
            $display("FAIL byp_ctrl got sel/ore/we=%b exp 110", {ram_byp_sel, ram_ore, ram_we}); end
        advance(a, p);
        wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== 32'hA5A5_0001 || fifo_count !== 5'd1) begin errors++;
            $display("FAIL byp_read got vld=%b pd=%h cnt=%0d exp 1 a5a50001 1", rd_pvld, rd_pd, fifo_count); end
        advance(a, p);
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b0 || fifo_count !== 5'd0) begin errors++;
            $display("FAIL byp_empty got vld=%b cnt=%0d exp 0 0", rd_pvld, fifo_count); end
        advance(a, p);
    endtask

    task automatic test_fill_drain();
        logic a, p;
        int pops;
        do_reset();
        rd_prdy = 1'b0;
        for (int k = 0; k < 21; k++) begin
            wr_pvld = 1'b1; wr_pd = 32'(k);
            @(negedge clk);
            checks++; if (wr_prdy !== 1'b1) begin errors++;
                $display("FAIL fill_rdy k=%0d got %b exp 1", k, wr_prdy); end
            if (k == 0) begin
                checks++; if ({ram_byp_sel, ram_we} !== 2'b10) begin errors++;
                    $display("FAIL fill_byp got sel/we=%b exp 10", {ram_byp_sel, ram_we}); end
            end else begin
                checks++; if (ram_we !== 1'b1 || ram_wa !== 5'(k - 1) || ram_byp_sel !== 1'b0) begin errors++;
                    $display("FAIL fill_wa k=%0d got we=%b wa=%0d exp 1 %0d", k, ram_we, ram_wa, k - 1); end
            end
            advance(a, p);
        end
        wr_pd = 32'd99;
        @(negedge clk);
        checks++; if (wr_prdy !== 1'b0 || fifo_count !== 5'd21) begin errors++;
            $display("FAIL full got rdy=%b cnt=%0d exp 0 21", wr_prdy, fifo_count); end
        advance(a, p);
        wr_pvld = 1'b0; rd_prdy = 1'b1; pops = 0;
        for (int i = 0; i < 30 && pops < 21; i++) begin
            @(negedge clk);
            if (rd_pvld === 1'b1) begin
                checks++; if (rd_pd !== 32'(pops)) begin errors++;
                    $display("FAIL drain_order got %h exp %h", rd_pd, 32'(pops)); end
            end
            advance(a, p);
            pops += int'(p);
        end
        checks++; if (pops != 21) begin errors++;
            $display("FAIL drain_count got %0d exp 21", pops); end
        // Write pointer has wrapped after 20 RAM writes.
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 32'h77;
        @(negedge clk); advance(a, p);
        wr_pd = 32'h78;
        @(negedge clk);
        checks++; if (ram_we !== 1'b1 || ram_wa !== 5'd0) begin errors++;
            $display("FAIL wa_wrap got we=%b wa=%0d exp 1 0", ram_we, ram_wa); end
        advance(a, p);
        wr_pvld = 1'b0;
    endtask

    task automatic test_full_pop_write();
        logic a, p;
        int got;
        do_reset();
        fill(21, got);
        checks++; if (got != 21) begin errors++;
            $display("FAIL full_fill got %0d exp 21", got); end
        wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 32'hBEEF;
        @(negedge clk);
        checks++; if (wr_prdy !== 1'b0 || fifo_count !== 5'd21 || rd_pd !== 32'd0) begin errors++;
            $display("FAIL full_pop got rdy=%b cnt=%0d pd=%h exp 0 21 0", wr_prdy, fifo_count, rd_pd); end
        advance(a, p);
        rd_prdy = 1'b0;
        @(negedge clk);
        checks++; if (wr_prdy !== 1'b1 || fifo_count !== 5'd20) begin errors++;
            $display("FAIL full_retry got rdy=%b cnt=%0d exp 1 20", wr_prdy, fifo_count); end
        advance(a, p);
        wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if (wr_prdy !== 1'b0 || fifo_count !== 5'd21 || rd_pd !== 32'd1) begin errors++;
            $display("FAIL full_again got rdy=%b cnt=%0d pd=%h exp 0 21 1", wr_prdy, fifo_count, rd_pd); end
        advance(a, p);
    endtask

    // Random traffic against the queue model, then a forced drain.
    task automatic test_stream(input string name, input int n, input int wr_pct, input int rd_pct);
        logic a, p, hold;
        logic [31:0] seq, hold_pd;
        int acc_n, pop_n;
        acc_n = 0; pop_n = 0; hold = 1'b0; hold_pd = '0;
        seq = $urandom;
        for (int i = 0; i < n + 60; i++) begin
            wr_pvld = (i < n) && (int'($urandom_range(99)) < wr_pct);
            wr_pd = seq;
            rd_prdy = (i >= n) || (int'($urandom_range(99)) < rd_pct);
            @(negedge clk);
            checks++; if (fifo_count !== 5'(q.size())) begin errors++;
                $display("FAIL %s_count i=%0d got %0d exp %0d", name, i, fifo_count, q.size()); end
            if (rd_pvld === 1'b1) begin
                checks++; if (q.size() == 0 || rd_pd !== q[0]) begin errors++;
                    $display("FAIL %s_data i=%0d got %h exp %h", name, i, rd_pd, (q.size() > 0) ? q[0] : 32'hx); end
            end
            if (hold) begin
                checks++; if (rd_pvld !== 1'b1 || rd_pd !== hold_pd) begin errors++;
                    $display("FAIL %s_stall i=%0d got vld=%b pd=%h exp 1 %h", name, i, rd_pvld, rd_pd, hold_pd); end
            end
            if (q.size() < 20) begin
                checks++; if (wr_prdy !== 1'b1) begin errors++;
                    $display("FAIL %s_rdy i=%0d got %b exp 1", name, i, wr_prdy); end
            end else if (q.size() == 21) begin
                checks++; if (wr_prdy !== 1'b0) begin errors++;
                    $display("FAIL %s_full i=%0d got %b exp 0", name, i, wr_prdy); end
            end
            if (ram_we === 1'b1) begin
                checks++; if (ram_di !== wr_pd || (ram_re === 1'b1 && ram_ra === ram_wa)) begin errors++;
                    $display("FAIL %s_wr i=%0d got di=%h ra=%0d wa=%0d exp di=%h", name, i, ram_di, ram_ra, ram_wa, wr_pd); end
            end
            hold = rd_pvld & ~rd_prdy;
            hold_pd = rd_pd;
            advance(a, p);
            if (a) seq = seq + 32'd1;
            acc_n += int'(a); pop_n += int'(p);
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if (q.size() != 0 || fifo_count !== 5'd0 || acc_n != pop_n) begin errors++;
            $display("FAIL %s_end got cnt=%0d acc=%0d pop=%0d exp 0 and equal", name, fifo_count, acc_n, pop_n); end
        if (wr_pct == 100 && rd_pct == 100) begin
            checks++; if (acc_n != n) begin errors++;
                $display("FAIL %s_rate got %0d exp %0d", name, acc_n, n); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        logic a, p;
        int got;
        do_reset();
        fill(10, got);
        rst = 1'b1; wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 32'hDEAD;
        @(negedge clk);
        checks++; if ({ram_we, ram_re, ram_ore} !== 3'b000) begin errors++;
            $display("FAIL midrst_en got %b exp 000", {ram_we, ram_re, ram_ore}); end
        advance(a, p);
        rst = 1'b0; wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if ({rd_pvld, wr_prdy, fifo_count} !== {1'b0, 1'b1, 5'd0}) begin errors++;
            $display("FAIL midrst_state got vld=%b rdy=%b cnt=%0d exp 0 1 0", rd_pvld, wr_prdy, fifo_count); end
        advance(a, p);
        wr_pvld = 1'b1; wr_pd = 32'h1234;
        @(negedge clk);
        checks++; if (ram_byp_sel !== 1'b1) begin errors++;
            $display("FAIL midrst_byp got %b exp 1", ram_byp_sel); end
        advance(a, p);
        wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== 32'h1234) begin errors++;
            $display("FAIL midrst_read got vld=%b pd=%h exp 1 00001234", rd_pvld, rd_pd); end
        advance(a, p);
    endtask

    initial begin
        test_reset();
        test_bypass_single();
        test_fill_drain();
        test_full_pop_write();
        do_reset();
        test_stream("stream", 100, 100, 100);
        test_stream("random", 400, 70, 50);
        test_stream("burst", 300, 90, 20);
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
